// File: rtl/wt_dcache_port_mux.sv
// N-to-1 round-robin load-port mux in front of one wt-dcache read controller, with
// in-order response routing through a port-ID FIFO. Optional perf counters: WT_DCACHE_PORT_MUX_PERF_EN.
module wt_dcache_port_mux #(
  parameter int NUM_PORTS       = 3,
  parameter int ADDR_W          = 56,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_PORTS-1:0]        up_req_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] up_addr_i,
  input  logic [NUM_PORTS*2-1:0]      up_size_i,
  output logic [NUM_PORTS-1:0]        up_gnt_o,
  output logic [NUM_PORTS-1:0]        up_rvalid_o,
  output logic [DATA_W-1:0]           up_rdata_o,
  output logic                        dn_req_o,
  output logic [ADDR_W-1:0]           dn_addr_o,
  output logic [1:0]                  dn_size_o,
  input  logic                        dn_gnt_i,
  input  logic                        dn_rvalid_i,
  input  logic [DATA_W-1:0]           dn_rdata_i,
  output logic                        err_o
`ifdef WT_DCACHE_PORT_MUX_PERF_EN
  ,
  output logic [NUM_PORTS*32-1:0]     perf_gnt_cnt_o,
  output logic [31:0]                 perf_stall_cnt_o
`endif
);

  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam logic [PTR_W:0]    MAX_CNT   = (PTR_W+1)'(MAX_OUTSTANDING);
  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

  logic [PORT_W-1:0] id_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [PORT_W-1:0] rr_ptr;
  logic              err_q;

  logic                 full, hs, pop, found;
  logic [NUM_PORTS-1:0] eligible;
  logic [PORT_W-1:0]    winner, head;
  int                   p;

  // Outputs are held off while reset is asserted, not just after it.
  assign full     = (count == MAX_CNT);
  assign eligible = (rst_i || full) ? '0 : up_req_i;
  assign dn_req_o = |eligible;
  assign hs       = dn_req_o & dn_gnt_i;
  assign pop      = dn_rvalid_i & ~rst_i & (count != '0);
  assign head     = id_fifo[rd_ptr];
  assign up_rdata_o = dn_rdata_i;
  assign err_o    = err_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    winner    = '0;
    found     = 1'b0;
    dn_addr_o = '0;
    dn_size_o = '0;
    p         = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p = int'(rr_ptr) + i;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!found && eligible[p]) begin
        found     = 1'b1;
        winner    = PORT_W'(p);
        dn_addr_o = up_addr_i[p*ADDR_W +: ADDR_W];
        dn_size_o = up_size_i[2*p +: 2];
      end
    end
  end

  always_comb begin
    up_gnt_o    = '0;
    up_rvalid_o = '0;
    if (hs)  up_gnt_o[winner]  = 1'b1;
    if (pop) up_rvalid_o[head] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      if (hs) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (winner == LAST_PORT) ? '0 : winner + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (dn_rvalid_i && count == '0) err_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; entries are only read behind a non-zero count.
  always_ff @(posedge clk_i) begin
    if (hs) id_fifo[wr_ptr] <= winner;
  end

`ifdef WT_DCACHE_PORT_MUX_PERF_EN
  logic [31:0] gnt_cnt [NUM_PORTS];
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PORTS; i++) gnt_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (up_gnt_o[i]) gnt_cnt[i] <= gnt_cnt[i] + 32'd1;
      end
      if (|up_req_i && !dn_req_o) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_comb begin
    perf_gnt_cnt_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) perf_gnt_cnt_o[i*32 +: 32] = gnt_cnt[i];
  end
  assign perf_stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_wt_dcache_port_mux.sv
// Directed bench for wt_dcache_port_mux: grants checked at drive time, response routing
// checked against a queue of granted port IDs.
module tb_wt_dcache_port_mux;
  localparam int NP = 3;
  localparam int AW = 56;
  localparam int DW = 64;
  localparam int MO = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NP-1:0]     up_req_i;
  logic [NP*AW-1:0]  up_addr_i;
  logic [NP*2-1:0]   up_size_i;
  logic [NP-1:0]     up_gnt_o, up_rvalid_o;
  logic [DW-1:0]     up_rdata_o;
  logic              dn_req_o;
  logic [AW-1:0]     dn_addr_o;
  logic [1:0]        dn_size_o;
  logic              dn_gnt_i, dn_rvalid_i;
  logic [DW-1:0]     dn_rdata_i;
  logic              err_o;
`ifdef WT_DCACHE_PORT_MUX_PERF_EN
  logic [NP*32-1:0]  perf_gnt_cnt_o;
  logic [31:0]       perf_stall_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  wt_dcache_port_mux #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .up_req_i(up_req_i), .up_addr_i(up_addr_i), .up_size_i(up_size_i),
    .up_gnt_o(up_gnt_o), .up_rvalid_o(up_rvalid_o), .up_rdata_o(up_rdata_o),
    .dn_req_o(dn_req_o), .dn_addr_o(dn_addr_o), .dn_size_o(dn_size_o),
    .dn_gnt_i(dn_gnt_i), .dn_rvalid_i(dn_rvalid_i), .dn_rdata_i(dn_rdata_i),
    .err_o(err_o)
`ifdef WT_DCACHE_PORT_MUX_PERF_EN
    , .perf_gnt_cnt_o(perf_gnt_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int exp_q [$];
  logic [AW-1:0] addr_tab [NP];
  logic [1:0]    size_tab [NP];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [NP-1:0] req, input logic gnt, input logic rv,
                       input logic [DW-1:0] rd);
    up_req_i    = req;
    dn_gnt_i    = gnt;
    dn_rvalid_i = rv;
    dn_rdata_i  = rd;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // p < 0 means no grant is expected this cycle.
  task automatic exp_grant(input string tag, input int p);
    check({tag, "_dn_req"}, 64'(dn_req_o), 64'(p >= 0));
    check({tag, "_gnt"}, 64'(up_gnt_o), (p >= 0) ? (64'd1 << p) : 64'd0);
    if (p >= 0) begin
      check({tag, "_addr"}, 64'(dn_addr_o), 64'(addr_tab[p]));
      check({tag, "_size"}, 64'(dn_size_o), 64'(size_tab[p]));
      exp_q.push_back(p);
    end
  endtask

  task automatic exp_resp(input string tag);
    int p;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty_queue expected=pending_id", tag);
    end
    if (exp_q.size() != 0) begin
      p = exp_q.pop_front();
      check({tag, "_rvalid"}, 64'(up_rvalid_o), 64'd1 << p);
      check({tag, "_rdata"}, 64'(up_rdata_o), 64'(dn_rdata_i));
    end
  endtask

  initial begin
    addr_tab[0] = 56'h200;         size_tab[0] = 2'd3;
    addr_tab[1] = 56'h12_3456_789; size_tab[1] = 2'd1;
    addr_tab[2] = 56'h100;         size_tab[2] = 2'd2;
    for (int k = 0; k < NP; k++) begin
      up_addr_i[k*AW +: AW] = addr_tab[k];
      up_size_i[2*k +: 2]   = size_tab[k];
    end

    // Reset held two cycles with all ports requesting.
    rst_i = 1'b1;
    drive(3'b111, 1'b1, 1'b0, '0);
    exp_grant("rst0", -1);
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      drive(3'b111, 1'b1, 1'b0, '0);
      exp_grant("rst", -1);
      check("rst_rvalid", 64'(up_rvalid_o), 64'd0);
      check("rst_err", 64'(err_o), 64'd0);
    end
    next_cycle();
    rst_i = 1'b0;

    // Round-robin: grants cycle 0,1,2,0,1,2; each response retires the previous grant.
    for (int c = 0; c < 6; c++) begin
      drive(3'b111, 1'b1, c > 0, 64'hC0DE_0000 + 64'(c));
      exp_grant("rr", c % NP);
      if (c > 0) exp_resp("rr");
      next_cycle();
    end
    drive(3'b000, 1'b0, 1'b1, 64'hC0DE_0006);
    exp_grant("rr_end", -1);
    exp_resp("rr_end");
    next_cycle();
    check("rr_err", 64'(err_o), 64'd0);

    // Full: four grants to port 1, then stall; a pop alone does not re-open the grant.
    rst_i = 1'b1;
    drive(3'b000, 1'b0, 1'b0, '0);
    next_cycle();
    rst_i = 1'b0;
    for (int c = 0; c < MO; c++) begin
      drive(3'b010, 1'b1, 1'b0, '0);
      exp_grant("fill", 1);
      next_cycle();
    end
    drive(3'b010, 1'b1, 1'b0, '0);
    exp_grant("full", -1);
    next_cycle();
    drive(3'b010, 1'b1, 1'b1, 64'h55);
    exp_grant("full_pop", -1);
    exp_resp("full_pop");
    next_cycle();
    drive(3'b010, 1'b1, 1'b0, '0);
    exp_grant("resume", 1);
    next_cycle();
`ifdef WT_DCACHE_PORT_MUX_PERF_EN
    check("perf_gnt1", 64'(perf_gnt_cnt_o[32 +: 32]), 64'd5);
    check("perf_gnt0", 64'(perf_gnt_cnt_o[0 +: 32]), 64'd0);
    check("perf_stall", 64'(perf_stall_cnt_o), 64'd2);
`endif
    for (int c = 0; c < MO; c++) begin
      drive(3'b000, 1'b0, 1'b1, 64'h10 + 64'(c));
      exp_resp("drain");
      next_cycle();
    end
    check("full_err", 64'(err_o), 64'd0);

    // Ordering: p2 then p0 granted; responses route back in grant order.
    drive(3'b100, 1'b1, 1'b0, '0);
    exp_grant("ord_p2", 2);
    next_cycle();
    drive(3'b001, 1'b1, 1'b0, '0);
    exp_grant("ord_p0", 0);
    next_cycle();
    drive(3'b000, 1'b0, 1'b1, 64'hAA);
    exp_resp("ord_aa");
    next_cycle();
    drive(3'b000, 1'b0, 1'b1, 64'hBB);
    exp_resp("ord_bb");
    next_cycle();

    // rr pointer now at 1: ports 0 and 2 requesting -> 2 wins, pointer held while ungranted.
    drive(3'b101, 1'b0, 1'b0, '0);
    check("hold_dn_req", 64'(dn_req_o), 64'd1);
    check("hold_gnt", 64'(up_gnt_o), 64'd0);
    check("hold_addr", 64'(dn_addr_o), 64'(addr_tab[2]));
    next_cycle();
    drive(3'b101, 1'b1, 1'b0, '0);
    exp_grant("wrap_p2", 2);
    next_cycle();
    drive(3'b101, 1'b1, 1'b0, '0);
    exp_grant("wrap_p0", 0);
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      drive(3'b000, 1'b0, 1'b1, 64'hD0 + 64'(c));
      exp_resp("wrap_drain");
      next_cycle();
    end

    // Response with nothing in flight: no rvalid, sticky error until reset.
    drive(3'b000, 1'b0, 1'b1, 64'h77);
    check("err_rvalid", 64'(up_rvalid_o), 64'd0);
    check("err_pre", 64'(err_o), 64'd0);
    next_cycle();
    drive(3'b000, 1'b0, 1'b0, '0);
    check("err_set", 64'(err_o), 64'd1);
    next_cycle();
    check("err_hold", 64'(err_o), 64'd1);
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    drive(3'b000, 1'b0, 1'b0, '0);
    check("err_clr", 64'(err_o), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
